multi_rate_divider: RTL

MULTI_RATE_DIVIDER -- requirements
Module: multi_rate_divider

---
 rtl/multi_rate_divider.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/multi_rate_divider.sv
// Multi-channel programmable clock divider. Each channel counts down an interval of enabled
// cycles and, on each terminal count, either toggles its output level or emits a one-cycle
// strobe. Interval/mode changes on a running channel are shadowed and applied at the next
// wrap or synchronous clear, so the period in progress always completes.
module multi_rate_divider #(
    parameter int unsigned WIDTH    = 28,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_50,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [WIDTH-1:0]    cfg_interval,
    input  logic                cfg_mode,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] sync_clear,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] wrap
);

    // Active configuration, running counter and shadow configuration per channel.
    logic [WIDTH-1:0]    ival_q    [CHANNELS];
    logic [WIDTH-1:0]    ival_d    [CHANNELS];
    logic [WIDTH-1:0]    cnt_q     [CHANNELS];
    logic [WIDTH-1:0]    cnt_d     [CHANNELS];
    logic [WIDTH-1:0]    sh_ival_q [CHANNELS];
    logic [WIDTH-1:0]    sh_ival_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] sh_mode_q, sh_mode_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] wrap_q, wrap_d;

    // Reload source selection: same-cycle write, then pending shadow, then current config.
    logic [CHANNELS-1:0] wr_sel;
    logic [WIDTH-1:0]    src_ival [CHANNELS];
    logic [CHANNELS-1:0] src_mode;

    // Decode the write target and pick the reload source for every channel.
    always_comb begin
        wr_sel   = '0;
        src_mode = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            // Out-of-range indices never match any channel, so such writes fall away.
            wr_sel[i] = cfg_we && (cfg_ch == CW'(i));
            if (wr_sel[i]) begin
                src_ival[i] = cfg_interval;
                src_mode[i] = cfg_mode;
            end else if (pend_q[i]) begin
                src_ival[i] = sh_ival_q[i];
                src_mode[i] = sh_mode_q[i];
            end else begin
                src_ival[i] = ival_q[i];
                src_mode[i] = mode_q[i];
            end
        end
    end

    // Per-channel next-state: clear has priority, then idle load, then counting/wrap.
    always_comb begin
        ival_d    = ival_q;
        cnt_d     = cnt_q;
        sh_ival_d = sh_ival_q;
        mode_d    = mode_q;
        sh_mode_d = sh_mode_q;
        pend_d    = pend_q;
        out_d     = out_q;
        wrap_d    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sync_clear[i]) begin
                ival_d[i] = src_ival[i];
                mode_d[i] = src_mode[i];
                cnt_d[i]  = src_ival[i];
                pend_d[i] = 1'b0;
                out_d[i]  = 1'b0;
            end else if (ival_q[i] == '0) begin
                // Idle: en is ignored; a write takes effect immediately.
                out_d[i] = 1'b0;
                cnt_d[i] = '0;
                if (wr_sel[i]) begin
                    ival_d[i] = cfg_interval;
                    mode_d[i] = cfg_mode;
                    cnt_d[i]  = cfg_interval;
                end
            end else begin
                if (wr_sel[i]) begin
                    sh_ival_d[i] = cfg_interval;
                    sh_mode_d[i] = cfg_mode;
                    pend_d[i]    = 1'b1;
                end
                if (en[i] && (cnt_q[i] == WIDTH'(1))) begin
                    // Terminal count: reload, and drive the output per the new mode.
                    ival_d[i] = src_ival[i];
                    mode_d[i] = src_mode[i];
                    cnt_d[i]  = src_ival[i];
                    pend_d[i] = 1'b0;
                    if (src_ival[i] == '0) begin
                        out_d[i] = 1'b0;
                    end else begin
                        wrap_d[i] = 1'b1;
                        out_d[i]  = src_mode[i] ? 1'b1 : ~out_q[i];
                    end
                end else begin
                    if (en[i]) begin
                        cnt_d[i] = cnt_q[i] - WIDTH'(1);
                    end
                    if (mode_q[i]) begin
                        out_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // State registers with asynchronous clear; reset leaves every channel idle.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                ival_q[i]    <= '0;
                cnt_q[i]     <= '0;
                sh_ival_q[i] <= '0;
            end
            mode_q    <= '0;
            sh_mode_q <= '0;
            pend_q    <= '0;
            out_q     <= '0;
            wrap_q    <= '0;
        end else begin
            ival_q    <= ival_d;
            cnt_q     <= cnt_d;
            sh_ival_q <= sh_ival_d;
            mode_q    <= mode_d;
            sh_mode_q <= sh_mode_d;
            pend_q    <= pend_d;
            out_q     <= out_d;
            wrap_q    <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule
